axis_uart_tx_arbiter: RTL and testbench

- Shares one 8-bit AXI-Stream UART transmit path (feeding the UART TX wrapper) between NUM_SRC byte-stream requesters.
- Uses round-robin arbitration with packet lock: a grant is held until the source's tlast, or until MAX_BURST bytes have been sent.
- When HEADER_EN=1, a source-ID header byte is inserted ahead of each granted burst so the host can demultiplex.
- Sits between on-chip producers (dip-switch sampler, status reporters, debug taps) and the TX wrapper's i_tdata/i_tvalid/i_tready.

---
 rtl/axis_uart_tx_arbiter_if.sv | 23 ++
 rtl/axis_uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_tx_arbiter_if.sv
// Requester-side and UART-side AXI-Stream signals of the TX arbiter.
// slave = arbiter view, master = producers/consumer (testbench) view.
interface axis_uart_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC*8-1:0] s_tdata;
  logic [NUM_SRC-1:0]   s_tvalid;
  logic [NUM_SRC-1:0]   s_tlast;
  logic [NUM_SRC-1:0]   s_tready;
  logic [7:0]           m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked N:1 byte-stream arbiter in front of a UART TX
// AXI-Stream port; optionally prefixes every burst with an 8'hA0|id header.

module axis_uart_tx_arbiter_lane #(
  parameter int IDX = 0
) (
  input  logic [3:0] grant_id,
  input  logic       data_en,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  input  logic       tlast,
  output logic       tready,
  output logic [7:0] sel_tdata,
  output logic       sel_tvalid,
  output logic       sel_tlast
);
  logic sel;

  // Non-granted lanes contribute zeros so the top can OR-reduce the mux.
  assign sel        = (grant_id == 4'(IDX));
  assign tready     = sel & data_en;
  assign sel_tdata  = sel ? tdata : 8'h00;
  assign sel_tvalid = sel & tvalid;
  assign sel_tlast  = sel & tlast;
endmodule

module axis_uart_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int HEADER_EN = 1,
  parameter int MAX_BURST = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_uart_tx_arbiter_if.slave bus,
  output logic [3:0]            grant_id,
  output logic                  busy
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  logic [1:0]                state;
  logic [3:0]                last;
  logic [15:0]               cnt;
  logic [7:0]                tdata_q;
  logic                      tvalid_q;

  logic                      free;
  logic                      data_en;
  logic [NUM_SRC-1:0]        tready_v;
  logic [NUM_SRC-1:0]        lane_vld;
  logic [NUM_SRC-1:0]        lane_last;
  logic [NUM_SRC-1:0][7:0]   lane_data;
  logic [7:0]                g_data;
  logic                      g_vld;
  logic                      g_last;

  logic [15:0]               rr_req;
  logic [4:0]                rr_idx;
  logic                      rr_found;
  logic [3:0]                pick;
  logic [16:0]               cnt_nxt;
  logic                      burst_end;

  assign free    = !tvalid_q | bus.m_tready;
  assign data_en = (state == ST_DATA) & free;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
      axis_uart_tx_arbiter_lane #(.IDX(i)) u_lane (
        .grant_id   (grant_id),
        .data_en    (data_en),
        .tdata      (bus.s_tdata[8*i +: 8]),
        .tvalid     (bus.s_tvalid[i]),
        .tlast      (bus.s_tlast[i]),
        .tready     (tready_v[i]),
        .sel_tdata  (lane_data[i]),
        .sel_tvalid (lane_vld[i]),
        .sel_tlast  (lane_last[i])
      );
    end
  endgenerate

  always_comb begin
    g_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) g_data = g_data | lane_data[i];
    g_vld  = |lane_vld;
    g_last = |lane_last;
  end

  // First requester after the last grant, wrapping; pointer starts at NUM_SRC-1.
  always_comb begin
    rr_req   = 16'(bus.s_tvalid);
    rr_idx   = 5'd0;
    rr_found = 1'b0;
    pick     = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_idx = {1'b0, last} + 5'(k);
      if (rr_idx >= 5'(NUM_SRC)) rr_idx = rr_idx - 5'(NUM_SRC);
      if (!rr_found && rr_req[rr_idx[3:0]]) begin
        rr_found = 1'b1;
        pick     = rr_idx[3:0];
      end
    end
  end

  assign cnt_nxt   = {1'b0, cnt} + 17'd1;
  assign burst_end = (cnt_nxt == 17'(MAX_BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      grant_id <= 4'd0;
      last     <= 4'(NUM_SRC - 1);
      cnt      <= 16'd0;
    end else begin
      if (tvalid_q && bus.m_tready) tvalid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.s_tvalid) begin
            grant_id <= pick;
            last     <= pick;
            cnt      <= 16'd0;
            state    <= (HEADER_EN != 0) ? ST_HEADER : ST_DATA;
          end
        end
        ST_HEADER: begin
          if (free) begin
            tdata_q  <= 8'hA0 | {4'h0, grant_id};
            tvalid_q <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (free) begin
            if (g_vld) begin
              tdata_q  <= g_data;
              tvalid_q <= 1'b1;
              cnt      <= cnt_nxt[15:0];
              if (g_last || burst_end) state <= ST_FLUSH;
            end else begin
              // Source stalled mid-packet: keep the grant, just idle the stage.
              tvalid_q <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (free) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_tdata  = tdata_q;
  assign bus.m_tvalid = tvalid_q;
  assign bus.s_tready = tready_v;
  assign busy         = (state != ST_IDLE) | tvalid_q;
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: queued random packets checked against a
// packet-level round-robin model, plus directed reset / no-header cases.
module tb_axis_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_uart_tx_arbiter_if #(.NUM_SRC(N)) bus_a ();
  axis_uart_tx_arbiter_if #(.NUM_SRC(N)) bus_b ();
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b;

  axis_uart_tx_arbiter #(.NUM_SRC(N), .HEADER_EN(1), .MAX_BURST(MB)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .grant_id(grant_a), .busy(busy_a));
  axis_uart_tx_arbiter #(.NUM_SRC(N), .HEADER_EN(0), .MAX_BURST(64)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .grant_id(grant_b), .busy(busy_b));

  int checks = 0;
  int failures = 0;
  logic [8:0] src_q [N][$];
  logic [8:0] mq    [N][$];
  logic [8:0] exp_q [$];
  logic [N-1:0] mid = '0;
  int m_last = N - 1;
  int rdy_pct = 100;
  int gap_pct = 0;
  logic pat_en = 1'b0;
  logic [3:0] pat = 4'b1111;
  int cyc_n = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] bd [8];
  int bidx, bgot, brun, bbest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input logic l);
    src_q[s].push_back({l, b});
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int j = 0; j < len; j++) push(s, 8'($urandom), (j == len - 1) ? 1'b1 : 1'b0);
  endtask

  // Whole-stream prediction: every queued byte is offered from the start, so
  // each grant goes to the next non-empty source and runs to tlast or MB bytes.
  task automatic build_model();
    int g, n;
    logic [8:0] e;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    while (1) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int si;
        si = (m_last + k) % N;
        if (g < 0 && mq[si].size() > 0) g = si;
      end
      if (g < 0) break;
      exp_q.push_back({1'b1, 8'hA0 | 8'(g)});
      n = 0;
      do begin
        e = mq[g].pop_front();
        exp_q.push_back({1'b0, e[7:0]});
        n++;
      end while (!e[8] && n < MB && mq[g].size() > 0);
      m_last = g;
    end
  endtask

  task automatic cyc();
    logic [N-1:0] v;
    logic [8:0] e;
    @(negedge clk);
    cyc_n++;
    bus_a.m_tready = pat_en ? pat[2'(cyc_n)] : (int'($urandom_range(99)) < rdy_pct);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !(mid[i] && int'($urandom_range(99)) < gap_pct)) begin
        v[i] = 1'b1;
        bus_a.s_tdata[8*i +: 8] = src_q[i][0][7:0];
        bus_a.s_tlast[i] = src_q[i][0][8];
      end else begin
        v[i] = 1'b0;
        bus_a.s_tdata[8*i +: 8] = 8'($urandom);
        bus_a.s_tlast[i] = 1'($urandom);
      end
    end
    bus_a.s_tvalid = v;
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(bus_a.m_tvalid), 32'd1);
      check("hold_data", 32'(bus_a.m_tdata), 32'(prev_data));
    end
    check("ready_onehot", 32'($onehot0(bus_a.s_tready)), 32'd1);
    if (bus_a.m_tvalid && !bus_a.m_tready) check("stall_ready", 32'(bus_a.s_tready), 32'd0);
    if (bus_a.m_tvalid && bus_a.m_tready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL extra_byte observed=%0h expected=none", bus_a.m_tdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[8]) begin
          check("header", 32'(bus_a.m_tdata), 32'(e[7:0]));
          check("grant_id", 32'(grant_a), 32'(e[3:0]));
        end else begin
          check("byte", 32'(bus_a.m_tdata), 32'(e[7:0]));
        end
      end
    end
    prev_stall = bus_a.m_tvalid & !bus_a.m_tready;
    prev_data  = bus_a.m_tdata;
    for (int i = 0; i < N; i++)
      if (v[i] && bus_a.s_tready[i]) begin
        e = src_q[i].pop_front();
        mid[i] = !e[8];
      end
  endtask

  task automatic run(input int max_cyc);
    int c;
    int left;
    c = 0;
    build_model();
    while (exp_q.size() > 0 && c < max_cyc) begin
      cyc();
      c++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL run_timeout observed=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
    end
    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    check("src_drained", 32'(left), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    pat_en = 1'b0; rdy_pct = 100; gap_pct = 0;
    cyc();
    cyc();
    check("idle_valid", 32'(bus_a.m_tvalid), 32'd0);
    check("idle_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.s_tvalid = '0;
    bus_b.s_tvalid = '0;
    #1;
    check("rst_valid", 32'(bus_a.m_tvalid), 32'd0);
    check("rst_data", 32'(bus_a.m_tdata), 32'd0);
    check("rst_ready", 32'(bus_a.s_tready), 32'd0);
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    m_last = N - 1;
    mid = '0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus_a.s_tdata = '0; bus_a.s_tvalid = '0; bus_a.s_tlast = '0; bus_a.m_tready = 1'b0;
    bus_b.s_tdata = '0; bus_b.s_tvalid = '0; bus_b.s_tlast = '0; bus_b.m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("init_valid", 32'(bus_a.m_tvalid), 32'd0);
    check("init_data", 32'(bus_a.m_tdata), 32'd0);
    check("init_ready", 32'(bus_a.s_tready), 32'd0);
    check("init_grant", 32'(grant_a), 32'd0);
    check("init_busy", 32'(busy_a), 32'd0);
    check("init_b_valid", 32'(bus_b.m_tvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single source, A2 11 22 33
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    run(50);

    // all four at once, then source 1 alone
    do_reset();
    for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
    run(100);
    push(1, 8'h11, 1'b1);
    run(50);
    check("last_grant", 32'(grant_a), 32'd1);

    // backpressure 1,0,0,1
    pat_en = 1'b1; pat = 4'b1001;
    add_pkt(0, 4);
    run(100);

    // MAX_BURST truncation with another source pending
    do_reset();
    add_pkt(0, 6); add_pkt(1, 2);
    run(100);

    // granted source dropping valid mid-packet
    gap_pct = 50; rdy_pct = 80;
    add_pkt(0, 4); add_pkt(1, 3); add_pkt(2, 2);
    run(300);

    // random packet mixes
    for (int r = 0; r < 8; r++) begin
      rdy_pct = 40 + int'($urandom_range(60));
      for (int i = 0; i < N; i++) begin
        int np;
        np = int'($urandom_range(2));
        for (int p = 0; p < np; p++) add_pkt(i, 1 + int'($urandom_range(6)));
      end
      run(1000);
    end

    // reset mid-packet, then source 0 must win first
    rdy_pct = 100;
    add_pkt(1, 6);
    build_model();
    repeat (4) cyc();
    do_reset();
    add_pkt(2, 2); add_pkt(0, 2);
    run(100);

    // no-header instance: 8 back-to-back bytes from source 3
    for (int j = 0; j < 8; j++) bd[j] = 8'($urandom);
    bus_b.m_tready = 1'b1;
    bidx = 0; bgot = 0; brun = 0; bbest = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus_b.s_tvalid = (bidx < 8) ? 4'b1000 : 4'b0000;
      bus_b.s_tdata  = {bd[(bidx < 8) ? bidx : 0], 24'h0};
      bus_b.s_tlast  = (bidx == 7) ? 4'b1000 : 4'b0000;
      #1;
      if (bus_b.m_tvalid) begin
        brun++;
        if (brun > bbest) bbest = brun;
        if (bgot < 8) check("b_byte", 32'(bus_b.m_tdata), 32'(bd[bgot]));
        else check("b_extra", 32'(bgot), 32'd7);
        bgot++;
      end else begin
        brun = 0;
      end
      if (bus_b.s_tvalid[3] && bus_b.s_tready[3]) bidx++;
    end
    check("b_count", 32'(bgot), 32'd8);
    check("b_run", 32'(bbest), 32'd8);
    check("b_busy", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
